// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: issues data-memory requests, waits for load responses
// with a timeout, and registers the write-back fields plus a forwarding value.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_e_i,
  input  logic              mem_re_e_i,
  input  logic              mem_we_e_i,
  input  logic [2:0]        dmem_type_e_i,
  input  logic [31:0]       alu_result_e_i,
  input  logic [31:0]       store_data_e_i,
  input  logic [31:0]       extended_imm_e_i,
  input  logic [31:0]       pc_plus4_e_i,
  input  logic              reg_write_en_e_i,
  input  logic [IDX_W-1:0]  rd_idx_e_i,
  input  logic [3:0]        result_src_e_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              stall_m_o,
  output logic              valid_m_o,
  output logic [31:0]       mem_read_data_m_o,
  output logic [31:0]       alu_result_m_o,
  output logic [31:0]       extended_imm_m_o,
  output logic [31:0]       pc_plus4_m_o,
  output logic              reg_write_en_m_o,
  output logic [IDX_W-1:0]  rd_idx_m_o,
  output logic [3:0]        result_src_m_o,
  output logic              misaligned_m_o,
  output logic              bus_err_m_o,
  output logic [31:0]       bypass_m_o
);

  typedef enum logic [0:0] {StIdle, StWaitResp} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYC - 1);

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [1:0]         off_q;
  logic [2:0]         type_q;
  logic [IDX_W-1:0]   rd_q;
  logic [3:0]         src_q;
  logic               rwe_q;
  logic [31:0]        alu_q;

  logic        in_idle, mem_op, misal, mis_op, issue, timeout;
  logic [1:0]  off;
  logic [31:0] shifted, load_data;

  assign in_idle = (state_q == StIdle);
  assign off     = alu_result_e_i[1:0];
  assign mem_op  = mem_re_e_i | mem_we_e_i;
  assign misal   = ((dmem_type_e_i[1:0] == 2'b01) && off[0]) ||
                   ((dmem_type_e_i[1:0] == 2'b10) && (off != 2'b00));
  assign mis_op  = mem_op & misal;
  assign issue   = resetn & in_idle & valid_e_i & mem_op & ~misal;
  assign timeout = ~in_idle & ~dmem_rvalid_i & (cnt_q == LastCnt);

  assign dmem_req_o  = issue;
  assign dmem_we_o   = issue & mem_we_e_i;
  assign dmem_addr_o = {alu_result_e_i[ADDR_W-1:2], 2'b00};

  // Stall also drops on the timeout cycle so upstream does not replay the failed load.
  assign stall_m_o = resetn & (in_idle ? (issue & (~mem_we_e_i | ~dmem_gnt_i))
                                       : ~(dmem_rvalid_i | timeout));

  always_comb begin
    dmem_wdata_o = store_data_e_i;
    dmem_be_o    = 4'b1111;
    case (dmem_type_e_i[1:0])
      2'b00: begin
        dmem_wdata_o = {4{store_data_e_i[7:0]}};
        dmem_be_o    = 4'b0001 << off;
      end
      2'b01: begin
        dmem_wdata_o = {2{store_data_e_i[15:0]}};
        dmem_be_o    = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  assign shifted = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (type_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    bypass_m_o = '0;
    if (valid_m_o) begin
      case (result_src_m_o)
        4'b0001: bypass_m_o = alu_result_m_o;
        4'b0010: bypass_m_o = mem_read_data_m_o;
        4'b0100: bypass_m_o = extended_imm_m_o;
        4'b1000: bypass_m_o = pc_plus4_m_o;
        default: bypass_m_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      off_q             <= '0;
      type_q            <= '0;
      rd_q              <= '0;
      src_q             <= '0;
      rwe_q             <= 1'b0;
      alu_q             <= '0;
      valid_m_o         <= 1'b0;
      mem_read_data_m_o <= '0;
      alu_result_m_o    <= '0;
      extended_imm_m_o  <= '0;
      pc_plus4_m_o      <= '0;
      reg_write_en_m_o  <= 1'b0;
      rd_idx_m_o        <= '0;
      result_src_m_o    <= '0;
      misaligned_m_o    <= 1'b0;
      bus_err_m_o       <= 1'b0;
    end else begin
      extended_imm_m_o <= extended_imm_e_i;
      pc_plus4_m_o     <= pc_plus4_e_i;
      bus_err_m_o      <= 1'b0;
      misaligned_m_o   <= 1'b0;
      case (state_q)
        StIdle: begin
          alu_result_m_o    <= alu_result_e_i;
          rd_idx_m_o        <= rd_idx_e_i;
          result_src_m_o    <= result_src_e_i;
          mem_read_data_m_o <= '0;
          valid_m_o         <= valid_e_i & ~stall_m_o;
          reg_write_en_m_o  <= valid_e_i & ~stall_m_o & ~mis_op & reg_write_en_e_i;
          misaligned_m_o    <= valid_e_i & mis_op;
          if (issue && !mem_we_e_i && dmem_gnt_i) begin
            state_q <= StWaitResp;
            cnt_q   <= '0;
            off_q   <= off;
            type_q  <= dmem_type_e_i;
            rd_q    <= rd_idx_e_i;
            src_q   <= result_src_e_i;
            rwe_q   <= reg_write_en_e_i;
            alu_q   <= alu_result_e_i;
          end
        end
        StWaitResp: begin
          alu_result_m_o   <= alu_q;
          rd_idx_m_o       <= rd_q;
          result_src_m_o   <= src_q;
          valid_m_o        <= dmem_rvalid_i | timeout;
          reg_write_en_m_o <= dmem_rvalid_i & rwe_q;
          bus_err_m_o      <= timeout;
          if (dmem_rvalid_i) mem_read_data_m_o <= load_data;
          if (dmem_rvalid_i || timeout) state_q <= StIdle;
          else cnt_q <= cnt_q + 8'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
